// File: rtl/cmt_fsk_rx.sv
// FSK cassette receiver. Measures half-periods of the tape signal, turns them
// into 600 baud bits, and deframes async 8N1/8N2 characters into a byte buffer
// that has rdy, overrun and framing flags.
//
// state  | meaning
// HUNT   | waiting for LEAD_BITS consecutive marks (leader)
// IDLE   | leader seen, line at mark, waiting for a start bit
// DATA   | shifting in 8 data bits, LSB first
// STOP   | expecting the stop bit
module cmt_fsk_rx #(
  parameter int MIN_HALF  = 5000,
  parameter int SHORT_MAX = 15000,
  parameter int LOSS_CNT  = 30000,
  parameter int LEAD_BITS = 8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       cmt_in_i,
  input  logic       ack_i,
  output logic [7:0] data_o,
  output logic       rdy_o,
  output logic       oe_o,
  output logic       fe_o,
  output logic       carrier_o
);

  typedef enum logic [1:0] {S_HUNT, S_IDLE, S_DATA, S_STOP} state_t;

  state_t      state_q, state_d;
  logic        meta_q, sync_q, prev_q, edge_q;
  logic [15:0] hcnt_q, hcnt_d;
  logic        primed_q, primed_d, carrier_q, carrier_d;
  logic [3:0]  acc_q, acc_d, nshort_q, nshort_d;
  logic [7:0]  markrun_q, markrun_d;
  logic [2:0]  bidx_q, bidx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  data_q;
  logic        rdy_q, oe_q, fe_q;

  logic        edge_ok, lost, classify, is_short, bit_v, bit_val;
  logic [3:0]  acc_sum, ns_sum;
  logic        deliver, deliver_fe;

  // Synchronise the pin and register a one-clk pulse on every level change
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      meta_q <= cmt_in_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      edge_q <= sync_q ^ prev_q;
    end
  end

  // Half-period timing, carrier tracking and short/long accumulation into bits
  always_comb begin
    edge_ok  = edge_q && (hcnt_q >= 16'(MIN_HALF));
    lost     = (hcnt_q == 16'(LOSS_CNT));
    // the first accepted edge after reset/loss has no reference point, so it is not classified
    classify = edge_ok && primed_q && !lost;
    is_short = (hcnt_q < 16'(SHORT_MAX));
    acc_sum  = acc_q + (is_short ? 4'd1 : 4'd2);
    ns_sum   = nshort_q + {3'b000, is_short};
    bit_v    = classify && (acc_sum >= 4'd8);
    bit_val  = (ns_sum >= 4'd4);

    hcnt_d    = edge_ok ? 16'd0 : (lost ? hcnt_q : hcnt_q + 16'd1);
    carrier_d = edge_ok ? 1'b1 : (lost ? 1'b0 : carrier_q);
    primed_d  = edge_ok ? 1'b1 : (lost ? 1'b0 : primed_q);
    acc_d     = acc_q;
    nshort_d  = nshort_q;
    if (lost) begin
      acc_d    = 4'd0;
      nshort_d = 4'd0;
    end else if (classify) begin
      acc_d    = bit_v ? acc_sum - 4'd8 : acc_sum;
      nshort_d = bit_v ? 4'd0 : ns_sum;
    end
  end

  // Timing and bit-former registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hcnt_q    <= 16'd0;
      carrier_q <= 1'b0;
      primed_q  <= 1'b0;
      acc_q     <= 4'd0;
      nshort_q  <= 4'd0;
    end else begin
      hcnt_q    <= hcnt_d;
      carrier_q <= carrier_d;
      primed_q  <= primed_d;
      acc_q     <= acc_d;
      nshort_q  <= nshort_d;
    end
  end

  // Frame FSM state register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_HUNT;
    else         state_q <= state_d;
  end

  // Frame FSM next state, advanced once per emitted bit
  always_comb begin
    state_d = state_q;
    if (lost) begin
      state_d = S_HUNT;
    end else if (bit_v) begin
      case (state_q)
        S_HUNT:  if (bit_val && markrun_q == 8'(LEAD_BITS - 1)) state_d = S_IDLE;
        S_IDLE:  if (!bit_val) state_d = S_DATA;
        S_DATA:  if (bidx_q == 3'd7) state_d = S_STOP;
        S_STOP:  state_d = bit_val ? S_IDLE : S_HUNT;
        default: state_d = S_HUNT;
      endcase
    end
  end

  // Frame FSM outputs: leader count, shift register, bit index, delivery strobe
  always_comb begin
    markrun_d  = markrun_q;
    bidx_d     = bidx_q;
    shreg_d    = shreg_q;
    deliver    = 1'b0;
    deliver_fe = 1'b0;
    if (lost) begin
      markrun_d = 8'd0;
    end else if (bit_v) begin
      case (state_q)
        S_HUNT: markrun_d = bit_val ? markrun_q + 8'd1 : 8'd0;
        S_IDLE: begin
          markrun_d = 8'd0;
          bidx_d    = 3'd0;
        end
        S_DATA: begin
          shreg_d = {bit_val, shreg_q[7:1]};
          bidx_d  = bidx_q + 3'd1;
        end
        S_STOP: begin
          deliver    = 1'b1;
          deliver_fe = !bit_val;
        end
        default: markrun_d = 8'd0;
      endcase
    end
  end

  // Frame datapath registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      markrun_q <= 8'd0;
      bidx_q    <= 3'd0;
      shreg_q   <= 8'd0;
    end else begin
      markrun_q <= markrun_d;
      bidx_q    <= bidx_d;
      shreg_q   <= shreg_d;
    end
  end

  // Output buffer: a delivery outranks a simultaneous ack; a full buffer drops the byte and flags overrun
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q <= 8'h00;
      rdy_q  <= 1'b0;
      oe_q   <= 1'b0;
      fe_q   <= 1'b0;
    end else if (deliver) begin
      if (ack_i) begin
        data_q <= shreg_q;
        rdy_q  <= 1'b1;
        oe_q   <= 1'b0;
        fe_q   <= deliver_fe;
      end else if (!rdy_q) begin
        data_q <= shreg_q;
        rdy_q  <= 1'b1;
        fe_q   <= fe_q | deliver_fe;
      end else begin
        oe_q <= 1'b1;
        fe_q <= fe_q | deliver_fe;
      end
    end else if (ack_i) begin
      rdy_q <= 1'b0;
      oe_q  <= 1'b0;
      fe_q  <= 1'b0;
    end
  end

  assign data_o    = data_q;
  assign rdy_o     = rdy_q;
  assign oe_o      = oe_q;
  assign fe_o      = fe_q;
  assign carrier_o = carrier_q;

endmodule

// File: tb/tb_cmt_fsk_rx.sv
// Testbench for cmt_fsk_rx with timing scaled down (short half 20 clks, long 40).
module tb_cmt_fsk_rx;

  localparam int MIN_HALF  = 10;
  localparam int SHORT_MAX = 30;
  localparam int LOSS_CNT  = 60;
  localparam int LEAD_BITS = 8;
  localparam int SH = 20;
  localparam int LH = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmt_in = 1'b0;
  logic       ack = 1'b0;
  logic [7:0] data;
  logic       rdy, oe, fe, carrier;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];
  logic       rdy_seen = 1'b0;

  cmt_fsk_rx #(
    .MIN_HALF(MIN_HALF), .SHORT_MAX(SHORT_MAX), .LOSS_CNT(LOSS_CNT), .LEAD_BITS(LEAD_BITS)
  ) dut (
    .clk_i(clk), .reset_i(reset), .cmt_in_i(cmt_in), .ack_i(ack),
    .data_o(data), .rdy_o(rdy), .oe_o(oe), .fe_o(fe), .carrier_o(carrier)
  );

  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic half(input int len, input bit glitch);
    if (glitch) begin
      wait_clk(2); cmt_in = ~cmt_in;
      wait_clk(4); cmt_in = ~cmt_in;
      wait_clk(len - 6);
    end else begin
      wait_clk(len);
    end
    cmt_in = ~cmt_in;
  endtask

  task automatic send_bit(input bit b, input bit g);
    if (b) repeat (8) half(SH, g);
    else   repeat (4) half(LH, g);
  endtask

  task automatic leader(input int n);
    repeat (n) send_bit(1'b1, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] d, input int nstop, input bit g);
    send_bit(1'b0, g);
    for (int i = 0; i < 8; i++) send_bit(d[i], g);
    repeat (nstop) send_bit(1'b1, g);
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic f, input logic o);
    exp_q.push_back({d, f, o});
  endtask

  task automatic do_ack;
    @(posedge clk); #1 ack = 1'b1;
    @(posedge clk); #1 ack = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    wait_clk(3);
    reset = 1'b0;
  endtask

  // Monitor: every rising rdy is a delivered byte; compare against the oldest expectation
  always @(negedge clk) begin
    if (rdy && !rdy_seen) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rdy: got data=%h fe=%b oe=%b with nothing expected", data, fe, oe);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({data, fe, oe} !== e) begin
          errors++;
          $display("FAIL rx_byte: got data=%h fe=%b oe=%b expected data=%h fe=%b oe=%b",
                   data, fe, oe, e[9:2], e[1], e[0]);
        end
      end
    end
    rdy_seen = rdy;
  end

  initial begin
    do_reset();
    check("reset_outputs", {data, rdy, oe}, 10'h000);
    check("reset_flags", {8'h00, fe, carrier}, 10'h000);

    // 12-bit leader then 0x5A with two stop bits
    half(SH, 1'b0);
    leader(12);
    expect_byte(8'h5A, 1'b0, 1'b0);
    send_byte(8'h5A, 2, 1'b0);
    wait_clk(10);
    check("carrier_on", {9'h0, carrier}, 10'h001);
    do_ack();
    check("ack_clears_rdy", {9'h0, rdy}, 10'h000);

    // 0x00 then 0xFF without ack: second byte overruns
    expect_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h00, 2, 1'b0);
    send_byte(8'hFF, 2, 1'b0);
    wait_clk(10);
    check("overrun_data_kept", {data, rdy, oe}, {8'h00, 1'b1, 1'b1});
    do_ack();
    check("ack_clears_oe", {8'h00, rdy, oe}, 10'h000);

    // 0x33 with a space stop bit: framing error, back to HUNT
    expect_byte(8'h33, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(((8'h33 >> i) & 8'h01) != 8'h00, 1'b0);
    send_bit(1'b0, 1'b0);
    wait_clk(10);
    do_ack();
    check("ack_clears_fe", {8'h00, rdy, fe}, 10'h000);
    send_byte(8'h00, 1, 1'b0);
    wait_clk(10);
    check("hunt_ignores_start", {9'h0, rdy}, 10'h000);

    // leader then 0xA5 with short glitches in every half
    leader(LEAD_BITS);
    expect_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'hA5, 2, 1'b1);
    wait_clk(10);
    do_ack();

    // carrier loss mid-DATA drops the frame silently
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    wait_clk(80);
    check("carrier_lost", {8'h00, carrier, rdy}, 10'h000);
    half(SH, 1'b0);
    send_byte(8'h81, 2, 1'b0);
    wait_clk(10);
    check("after_loss_needs_leader", {9'h0, rdy}, 10'h000);
    leader(LEAD_BITS);
    expect_byte(8'h81, 1'b0, 1'b0);
    send_byte(8'h81, 2, 1'b0);
    wait_clk(10);
    check("carrier_back", {9'h0, carrier}, 10'h001);

    // reset mid-DATA with a byte still pending in the buffer
    leader(LEAD_BITS);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    do_reset();
    check("midframe_reset_outputs", {data, rdy, oe}, 10'h000);
    check("midframe_reset_flags", {8'h00, fe, carrier}, 10'h000);
    half(SH, 1'b0);
    send_byte(8'h3C, 2, 1'b0);
    wait_clk(10);
    check("after_reset_needs_leader", {9'h0, rdy}, 10'h000);
    leader(LEAD_BITS);
    expect_byte(8'h3C, 1'b0, 1'b0);
    send_byte(8'h3C, 2, 1'b0);
    wait_clk(20);

    check("pending_expectations", 10'(exp_q.size()), 10'h000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
